loader_write_fifo: RTL
======================

# loader_write_fifo

Write buffer between the game loader and the SDRAM controller. It captures single-cycle byte writes (22-bit address, 8-bit data) from the loader into a small FIFO. It replays them to the SDRAM port one entry per NES memory slot, holding each write valid for a whole slot period. Bursty download writes can no longer collide with slot boundaries or overwrite a pending write. It also reports when the loaded image has been fully committed to memory.

## Interface

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- AW, 22: address width.

Ports:
- clk  in  1  system clock, 21 MHz domain.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; driven high while no download is active.
- in_addr  in  AW  loader write address.
- in_data  in  8  loader write data.
- in_write  in  1  one-cycle write strobe from the loader.
- in_done  in  1  loader has consumed the whole image.
- slot  in  1  one-cycle strobe marking the start of each SDRAM slot, every 4th clk.
- mem_addr  out  AW  address presented to SDRAM.
- mem_data  out  8  data presented to SDRAM.
- mem_write  out  1  write request to SDRAM; held for one full slot period.
- count  out  $clog2(DEPTH)+1  entries currently stored.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky flag: a write was dropped.
- drained  out  1  in_done, empty and no write in flight.

## Operation

- Storage is a DEPTH-entry circular buffer of {addr, data}, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH. count is a separate register.
- **Push:** accepted when in_write=1 and either count<DEPTH or a pop occurs in the same cycle. The entry is written at wr_ptr, then wr_ptr increments.
- **Push while full with no pop:** the entry is discarded and overflow is set to 1. overflow stays set until clear or reset.
- **Pop:** occurs when slot=1 and count>0. The head entry is loaded into mem_addr/mem_data, mem_write is set to 1, and rd_ptr increments.
- **slot=1 with count=0:** mem_write goes to 0. mem_addr and mem_data hold their previous values.
- **Between slots:** mem_write, mem_addr and mem_data are stable. The output changes only on slot cycles.
- **count update:** +1 on an accepted push only, −1 on a pop only, unchanged when both occur.
- **No bypass:** an entry pushed in the same cycle as slot with count=0 is not popped. It issues at the next slot.
- **clear=1:** wr_ptr, rd_ptr, count, mem_write and overflow go to 0 on the next edge. clear takes priority over a simultaneous push or pop. mem_addr and mem_data hold their values.
- **drained:** registered; equals in_done & (count==0) & !mem_write, evaluated each cycle. It deasserts when clear is applied.
- There is no state machine beyond the FIFO pointers and the output register. The output is either IDLE (mem_write=0) or ISSUE (mem_write=1), and it is re-decided only on slot cycles.

## Timing

- **Reset (reset_n low, async):**
  - mem_addr=0, mem_data=0, mem_write=0
  - count=0, empty=1, full=0
  - overflow=0, drained=0
  - both pointers 0
- full and empty are combinational from count. All other outputs are registered.
- **Latency:** an in_write sampled at edge t is visible in count after edge t. If slot is sampled at edge s>t and this entry is the head, mem_write=1 from edge s to edge s'. Here s' is the next slot edge after s.
- **Minimum push-to-issue latency:** 1 clk (slot in the cycle after the push). Maximum, with an empty FIFO: 4 clk.
- **Throughput:** one entry per slot. The loader may push faster in bursts, provided the average rate is at most one byte per 4 clk.
- reset_n deasserting mid-operation affects only state. reset_n must be released synchronously to clk externally.

## Test plan

- **Reset then single write:** push {0x000010, 0xA5}; slot pulses every 4 clk → at the next slot mem_write=1 with mem_addr=0x000010, mem_data=0xA5, held 4 clk, then 0; count returns to 0.
- **Burst fill:** 8 pushes on consecutive clk, no slot → count=8, full=1. A 9th push sets overflow=1 and count stays 8. Then 8 slots → the 8 entries issue in order and empty=1.
- **Simultaneous push and pop when full:** count=8, in_write and slot in the same cycle → push accepted, count stays 8, overflow stays 0, pointers wrap correctly.
- **Same-cycle push into empty FIFO with slot:** mem_write stays 0 that slot and issues at the following slot.
- **clear mid-stream:** count=5 with mem_write=1, assert clear for 1 clk → count=0, mem_write=0, overflow=0. A subsequent push issues normally.
- **Drain detection:** push 3 bytes, assert in_done → drained=0 until the third write's slot period ends with count=0, then drained=1. Async reset_n low at any point → all outputs return to reset values immediately.

Source files
------------

// File: rtl/loader_write_fifo_if.sv
// Loader-side byte write strobe and SDRAM-side write request for loader_write_fifo.
// The master modport is the loader/bench view; the slave modport is the buffer's view.
interface loader_write_fifo_if #(
  parameter int AW = 22
);
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic          in_write;
  logic          in_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_write;

  modport master (
    output in_addr, in_data, in_write, in_done,
    input  mem_addr, mem_data, mem_write
  );

  modport slave (
    input  in_addr, in_data, in_write, in_done,
    output mem_addr, mem_data, mem_write
  );
endinterface

// File: rtl/loader_write_fifo.sv
// Buffers single-cycle loader byte writes and replays them to SDRAM one per slot,
// holding each write valid for a full slot period; flags drops and image completion.
module loader_write_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 22
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   slot,
  loader_write_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   drained
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [AW-1:0] addr_buf [DEPTH];
  logic [7:0]    data_buf [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [0:0]    state;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_data_q;
  logic          pop;
  logic          push;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Pop looks only at the registered count, so a same-cycle push into an
  // empty buffer waits for the following slot instead of bypassing.
  assign pop  = slot && !empty;
  assign push = bus.in_write && (!full || pop);

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_write = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      addr_buf[wr_ptr] <= bus.in_addr;
      data_buf[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow   <= 1'b0;
      drained    <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
      drained  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (bus.in_write && !push) overflow <= 1'b1;

      // The output register is only re-decided at slot starts; an empty
      // slot drops the request but keeps the last address/data on the bus.
      if (slot) begin
        if (pop) begin
          state      <= ISSUE;
          mem_addr_q <= addr_buf[rd_ptr];
          mem_data_q <= data_buf[rd_ptr];
        end else begin
          state <= IDLE;
        end
      end

      drained <= bus.in_done && empty && (state == IDLE);
    end
  end
endmodule
